// File: rtl/effect_controller_pkg.sv
// Shared audio package: default sample width and FIFO depth, the
// overflow counter width, the output-register state type and a
// saturating-increment helper for the overflow counter.
package effect_controller_pkg;

    localparam int DEFAULT_D_WIDTH = 16;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int OVF_COUNT_W     = 8;

    localparam logic [OVF_COUNT_W-1:0] OVF_COUNT_MAX = '1;

    // The output register is either empty or holding a sample for the
    // transmitter.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // The counter sticks at its maximum rather than wrapping back to zero.
    function automatic logic [OVF_COUNT_W-1:0] sat_inc(input logic [OVF_COUNT_W-1:0] value);
        return (value == OVF_COUNT_MAX) ? value : value + OVF_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset (clears pointers and level)
//   push   - write wdata this cycle
//   pop    - remove the head entry this cycle
//   wdata  - sample to write
//   rdata  - head entry while level > 0, otherwise 0
//   level  - current occupancy, 0..depth
module sync_fifo #(
    parameter  int width = 16,
    parameter  int depth = 16,
    localparam int ptr_w = $clog2(depth),
    localparam int lvl_w = ptr_w + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic [lvl_w-1:0] level
);

    logic [width-1:0] mem_q [depth];

    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [lvl_w-1:0] level_q, level_d;

    logic push_ok;
    logic pop_ok;

    // A push at full is legal only when the head leaves in the same
    // cycle. In that case wr_ptr equals rd_ptr, so the new sample lands in
    // the slot being vacated and becomes the last entry in line.
    // Pointers are ptr_w bits wide, so incrementing wraps modulo depth.
    always_comb begin
        pop_ok   = pop && (level_q != '0);
        push_ok  = push && ((level_q != lvl_w'(depth)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + lvl_w'(1);
            2'b01:   level_d = level_q - lvl_w'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale entries are never exposed because
    // rdata is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level = level_q;

endmodule

// File: rtl/effect_controller.sv
// Effect controller: buffers receiver samples in a FWFT FIFO, feeds them to
// an external effect stage, and holds each processed result in a one-entry
// output register for the DAC-side transmitter. Input samples that arrive
// while the FIFO is full and nothing leaves are dropped and counted.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   in_valid, in_data          - sample from the audio receiver
//   fx_data_ready, fx_data     - FIFO head offered to the effect stage
//   fx_read_enable             - effect stage consumes fx_data this cycle
//   fx_result, fx_result_valid - processed sample from the effect stage
//   out_valid, out_data        - processed sample for the transmitter
//   out_ready                  - transmitter accepts out_data this cycle
//   level                      - FIFO occupancy
//   overflow_count             - saturating count of dropped samples
module effect_controller
    import effect_controller_pkg::*;
#(
    parameter  int d_width = DEFAULT_D_WIDTH,
    parameter  int depth   = DEFAULT_DEPTH,
    localparam int lvl_w   = $clog2(depth) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [d_width-1:0] in_data,
    output logic                      fx_data_ready,
    output logic signed [d_width-1:0] fx_data,
    input  logic                      fx_read_enable,
    input  logic signed [d_width-1:0] fx_result,
    input  logic                      fx_result_valid,
    output logic                      out_valid,
    output logic signed [d_width-1:0] out_data,
    input  logic                      out_ready,
    output logic [lvl_w-1:0]          level,
    output logic [OVF_COUNT_W-1:0]    overflow_count
);

    out_state_e out_state_q, out_state_d;

    logic signed [d_width-1:0] out_data_q, out_data_d;
    logic [OVF_COUNT_W-1:0]    overflow_q, overflow_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [d_width-1:0] fifo_rdata;

    sync_fifo #(
        .width (d_width),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (level)
    );

    // A sample is only offered to the effect stage when the output register
    // can take its result next cycle, so a compliant effect stage never
    // produces a result that has nowhere to go.
    always_comb begin
        fx_data_ready = (level != '0) && ((out_state_q == OUT_EMPTY) || out_ready);
        fifo_pop      = fx_data_ready && fx_read_enable;
        fifo_push     = in_valid && ((level != lvl_w'(depth)) || fifo_pop);
        overflow_d    = overflow_q;
        if (in_valid && !fifo_push) begin
            overflow_d = sat_inc(overflow_q);
        end
    end

    // Output register state machine. A result arriving in the same cycle as
    // the transmitter handoff replaces the departing sample without a
    // bubble; a result arriving while the register is stalled is ignored.
    always_comb begin
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        case (out_state_q)
            OUT_EMPTY: begin
                if (fx_result_valid) begin
                    out_data_d  = fx_result;
                    out_state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready) begin
                    if (fx_result_valid) begin
                        out_data_d  = fx_result;
                        out_state_d = OUT_FULL;
                    end else begin
                        out_state_d = OUT_EMPTY;
                    end
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
            overflow_q  <= '0;
        end else begin
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign fx_data        = fifo_rdata;
    assign out_valid      = (out_state_q == OUT_FULL);
    assign out_data       = out_data_q;
    assign overflow_count = overflow_q;

endmodule

// File: doc/effect_controller.md
EFFECT_CONTROLLER -- requirements
Module: effect_controller

Interface
REQ-001 SHALL have parameter d_width, default 16, meaning signed sample width in bits.
REQ-002 SHALL have parameter depth, default 16, meaning sample FIFO depth; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a sample from the audio receiver is present this cycle.
REQ-006 SHALL have port in_data, input, d_width signed, meaning the receiver sample.
REQ-007 SHALL have port fx_data_ready, output, 1, meaning a sample is available to the effect stage (drives its i_data_ready).
REQ-008 SHALL have port fx_data, output, d_width signed, meaning the FIFO head sample (drives its i_data).
REQ-009 SHALL have port fx_read_enable, input, 1, meaning the effect stage consumes fx_data this cycle.
REQ-010 SHALL have port fx_result, input, d_width signed, meaning the processed sample from the effect stage.
REQ-011 SHALL have port fx_result_valid, input, 1, meaning fx_result is valid this cycle.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data holds a sample for the DAC-side transmitter.
REQ-013 SHALL have port out_data, output, d_width signed, meaning the processed sample.
REQ-014 SHALL have port out_ready, input, 1, meaning the transmitter accepts out_data this cycle.
REQ-015 SHALL have port level, output, log2(depth)+1, meaning the current FIFO occupancy.
REQ-016 SHALL have port overflow_count, output, 8, meaning a saturating count of dropped input samples.

Function
REQ-017 FIFO SHALL be first-word-fall-through: fx_data = head entry whenever level > 0, else 0.
REQ-018 fx_data_ready SHALL be combinational: (level > 0) AND (out_valid = 0 OR out_ready = 1).
REQ-019 Pop SHALL occur when fx_data_ready AND fx_read_enable; fx_read_enable while fx_data_ready = 0 SHALL be ignored.
REQ-020 Push SHALL occur when in_valid AND (level < depth OR pop in the same cycle).
REQ-021 On simultaneous push and pop, level SHALL be unchanged and ordering SHALL be preserved; at full, the new sample SHALL be accepted.
REQ-022 On in_valid while full with no pop, the sample SHALL be dropped and overflow_count SHALL increment, saturating at 255.
REQ-023 Read and write pointers SHALL wrap modulo depth; level SHALL be the only full/empty indicator.
REQ-024 On fx_result_valid, out_data SHALL load fx_result and out_valid SHALL be set on the next clock edge (1-cycle latency).
REQ-025 When out_valid AND out_ready with no fx_result_valid, out_valid SHALL clear on the next edge.
REQ-026 When fx_result_valid and the out_valid/out_ready handoff occur in the same cycle, the new sample SHALL load and out_valid SHALL stay 1.
REQ-027 fx_result_valid while out_valid = 1 AND out_ready = 0 SHALL be ignored; REQ-018 backpressure makes this unreachable with a compliant effect stage.
REQ-028 Throughput SHALL be one sample per cycle end to end when the effect stage and the transmitter are always ready.
REQ-029 Samples SHALL pass through unmodified; the block performs no arithmetic on data.

Reset
REQ-030 While reset = 1 at a clock edge: pointers = 0, level = 0, overflow_count = 0, out_valid = 0, out_data = 0.
REQ-031 While level = 0, fx_data SHALL be 0 and fx_data_ready SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all buffered and in-flight samples; in_valid during reset SHALL be ignored.
REQ-033 FIFO storage SHALL need no reset; unread entries SHALL never be visible on fx_data.

Structure
REQ-034 Default d_width and depth SHALL live in the shared audio package, together with the overflow counter width (8).
REQ-035 The FIFO SHALL be a sub-module named sync_fifo (FWFT, ports clk/reset/push/pop/wdata/rdata/level); the output register and counter stay in effect_controller.

Verification
REQ-036 Reset, then push 3, -3, 32767 with the effect stage and out_ready always high SHALL give out_data = 3, -3, 32767 in order, each 2 cycles after its push.
REQ-037 Push 16 samples with fx_read_enable = 0, then 3 more SHALL give level = 16 and overflow_count = 3; after draining, exactly the first 16 samples SHALL appear.
REQ-038 At level = 16, in_valid together with a pop SHALL give level = 16, overflow_count unchanged, and the new sample output 16th in line.
REQ-039 With out_valid = 1 and out_ready = 0 held for 5 cycles, fx_data_ready SHALL be 0, out_data SHALL be stable, and level SHALL not decrease.
REQ-040 300 pushes at full with no pop SHALL leave overflow_count at 255.
REQ-041 Reset asserted at level = 5 with out_valid = 1 SHALL clear level, out_valid and out_data on the next edge, and the next pushed sample SHALL be the next one output.
